fwd_scoreboard: RTL

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

---
 rtl/fwd_scoreboard_pkg.sv | 37 +++
 rtl/fwd_sb_lookup.sv | 35 +++
 rtl/fwd_scoreboard.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard.
//   AWIDTH       register address width
//   SEL_*        bypass select encodings (RF, EX base, WB base; +2*lane)
//   sb_entry_t   per-register scoreboard entry
//   sel_width()  select width for a given lane count
//   entry_busy() true while an entry's result cannot yet be forwarded
package fwd_scoreboard_pkg;

  localparam int unsigned AWIDTH      = 5;
  localparam int unsigned LANE_W      = 2;
  localparam int unsigned AGE_W       = 2;
  localparam logic [1:0]  AGE_MAX     = 2'd3;

  localparam int unsigned SEL_RF      = 0;
  localparam int unsigned SEL_EX_BASE = 1;
  localparam int unsigned SEL_WB_BASE = 2;

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
    logic              load;
    logic [AGE_W-1:0]  age;
  } sb_entry_t;

  function automatic int unsigned sel_width(input int unsigned lanes);
    return $clog2(2 * lanes + 1);
  endfunction

  // Stored age k means the producer is k+1 stages past issue by the time a
  // consumer issued now reads its operand, hence the +1 against the latency.
  function automatic logic entry_busy(input sb_entry_t e, input int unsigned load_lat);
    int unsigned lat;
    lat = e.load ? load_lat : 1;
    return e.valid && ((32'(e.age) + 1) < lat);
  endfunction

endpackage

// File: rtl/fwd_sb_lookup.sv
// Per-operand hazard and bypass-select lookup for one scoreboard entry.
//   i_addr  source register address
//   i_ent   scoreboard entry for i_addr
//   o_haz   operand not yet forwardable
//   o_sel   bypass select (SEL_RF / EX+2*lane / WB+2*lane)
module fwd_sb_lookup
  import fwd_scoreboard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned SELW     = 3
) (
  input  logic [AWIDTH-1:0] i_addr,
  input  sb_entry_t         i_ent,
  output logic              o_haz,
  output logic [SELW-1:0]   o_sel
);

  logic       w_live;
  logic [2:0] w_pipe_age;

  always_comb begin
    w_live     = (i_addr != '0) && i_ent.valid;
    w_pipe_age = {1'b0, i_ent.age} + 3'd1;
    o_haz      = w_live && entry_busy(i_ent, LOAD_LAT);
    o_sel      = SELW'(SEL_RF);
    if (w_live) begin
      if (w_pipe_age == 3'd1) begin
        o_sel = SELW'(SEL_EX_BASE + (32'(i_ent.lane) << 1));
      end else if (w_pipe_age == 3'd2) begin
        o_sel = SELW'(SEL_WB_BASE + (32'(i_ent.lane) << 1));
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Multi-lane issue scoreboard with operand-forwarding select generation.
// Optional feature macro: FWD_STALL_CNT_EN adds the f_o_stall_cnt output.
//   i_clk / i_rst        clock, synchronous active-low reset
//   is_i_valid           per-lane issue request (lane 0 oldest)
//   is_i_rs1/rs2/rd      per-lane register addresses (LANES*AWIDTH)
//   is_i_regwrite        per-lane destination write enable
//   is_i_memread         per-lane load flag
//   is_i_flush           kill instructions issued in the previous cycle
//   f_o_grant            per-lane in-order issue grant
//   f_o_sel_rs1/rs2      per-lane bypass selects (LANES*SELW), granted lanes only
//   f_o_stall            lane 0 valid but not granted
//   f_o_stall_cnt        stall cycle counter (FWD_STALL_CNT_EN only)
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter  int unsigned LANES    = 2,
  parameter  int unsigned NREGS    = 32,
  parameter  int unsigned LOAD_LAT = 2,
  localparam int unsigned SELW     = sel_width(LANES)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [LANES-1:0]        is_i_valid,
  input  logic [LANES*AWIDTH-1:0] is_i_rs1,
  input  logic [LANES*AWIDTH-1:0] is_i_rs2,
  input  logic [LANES*AWIDTH-1:0] is_i_rd,
  input  logic [LANES-1:0]        is_i_regwrite,
  input  logic [LANES-1:0]        is_i_memread,
  input  logic                    is_i_flush,
  output logic [LANES-1:0]        f_o_grant,
  output logic [LANES*SELW-1:0]   f_o_sel_rs1,
  output logic [LANES*SELW-1:0]   f_o_sel_rs2,
  output logic                    f_o_stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]             f_o_stall_cnt
`endif
);

  sb_entry_t             r_tab     [NREGS];
  sb_entry_t             w_tab_nxt [NREGS];
  sb_entry_t             w_ent_rs1 [LANES];
  sb_entry_t             w_ent_rs2 [LANES];
  logic [LANES-1:0]      w_haz_rs1, w_haz_rs2, w_haz, w_grant;
  logic [LANES*SELW-1:0] w_sel1, w_sel2;
  logic [AWIDTH-1:0]     w_a1, w_a2, w_rdj, w_rdi;
  logic                  w_ok;

  // Operand entry fetch; out-of-range addresses read as empty.
  always_comb begin
    w_a1 = '0;
    w_a2 = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_a1 = is_i_rs1[l*AWIDTH +: AWIDTH];
      w_a2 = is_i_rs2[l*AWIDTH +: AWIDTH];
      w_ent_rs1[l] = (32'(w_a1) < NREGS) ? r_tab[w_a1] : '0;
      w_ent_rs2[l] = (32'(w_a2) < NREGS) ? r_tab[w_a2] : '0;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fwd_sb_lookup #(.LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_rs1 (
      .i_addr (is_i_rs1[l*AWIDTH +: AWIDTH]),
      .i_ent  (w_ent_rs1[l]),
      .o_haz  (w_haz_rs1[l]),
      .o_sel  (w_sel1[l*SELW +: SELW])
    );
    fwd_sb_lookup #(.LOAD_LAT(LOAD_LAT), .SELW(SELW)) u_rs2 (
      .i_addr (is_i_rs2[l*AWIDTH +: AWIDTH]),
      .i_ent  (w_ent_rs2[l]),
      .o_haz  (w_haz_rs2[l]),
      .o_sel  (w_sel2[l*SELW +: SELW])
    );
  end

  // Hazards: table RAW, in-flight WAW, and RAW against older lanes of the bundle.
  always_comb begin
    w_haz       = '0;
    w_grant     = '0;
    f_o_sel_rs1 = '0;
    f_o_sel_rs2 = '0;
    w_rdj       = '0;
    w_rdi       = '0;
    w_ok        = i_rst && !is_i_flush;
    for (int unsigned j = 0; j < LANES; j++) begin
      w_haz[j] = w_haz_rs1[j] | w_haz_rs2[j];
      w_rdj    = is_i_rd[j*AWIDTH +: AWIDTH];
      if (is_i_regwrite[j] && (w_rdj != '0) && (32'(w_rdj) < NREGS) &&
          entry_busy(r_tab[w_rdj], LOAD_LAT)) begin
        w_haz[j] = 1'b1;
      end
      for (int unsigned i = 0; i < j; i++) begin
        w_rdi = is_i_rd[i*AWIDTH +: AWIDTH];
        if (is_i_valid[i] && is_i_regwrite[i] && (w_rdi != '0) &&
            ((w_rdi == is_i_rs1[j*AWIDTH +: AWIDTH]) ||
             (w_rdi == is_i_rs2[j*AWIDTH +: AWIDTH]))) begin
          w_haz[j] = 1'b1;
        end
      end
      w_ok       = w_ok && is_i_valid[j] && !w_haz[j];
      w_grant[j] = w_ok;
      if (w_grant[j]) begin
        f_o_sel_rs1[j*SELW +: SELW] = w_sel1[j*SELW +: SELW];
        f_o_sel_rs2[j*SELW +: SELW] = w_sel2[j*SELW +: SELW];
      end
    end
  end

  assign f_o_grant = w_grant;
  assign f_o_stall = i_rst && is_i_valid[0] && !w_grant[0];

  // Age/expire/flush every entry, then apply granted writes in lane order
  // so the youngest lane wins a same-rd collision.
  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      w_tab_nxt[r] = r_tab[r];
      if (r_tab[r].valid) begin
        if (is_i_flush && (r_tab[r].age == '0)) begin
          w_tab_nxt[r].valid = 1'b0;
        end else if (r_tab[r].age == AGE_MAX - 2'd1) begin
          w_tab_nxt[r].valid = 1'b0;
          w_tab_nxt[r].age   = AGE_MAX;
        end else begin
          w_tab_nxt[r].age = r_tab[r].age + 2'd1;
        end
      end
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      if (w_grant[l] && is_i_regwrite[l] &&
          (is_i_rd[l*AWIDTH +: AWIDTH] != '0) &&
          (32'(is_i_rd[l*AWIDTH +: AWIDTH]) < NREGS)) begin
        w_tab_nxt[is_i_rd[l*AWIDTH +: AWIDTH]] =
          '{valid: 1'b1, lane: LANE_W'(l), load: is_i_memread[l], age: '0};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (!i_rst) r_tab[r] <= '0;
      else        r_tab[r] <= w_tab_nxt[r];
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst)         r_stall_cnt <= '0;
    else if (f_o_stall) r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign f_o_stall_cnt = r_stall_cnt;
`endif

endmodule
